// File: rtl/axi_mem_responder.sv
// AXI slave backed by a word-addressed register memory. Write and read channels
// run as independent FSMs; every output is a flop.
module axi_mem_responder #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int ID_SIZE = 4,
    parameter int DEPTH   = 256
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [AW-1:0]      AWADDR,
    input  logic [ID_SIZE-1:0] AWID,
    input  logic [3:0]         AWLEN,
    input  logic [2:0]         AWSIZE,
    input  logic [1:0]         AWBURST,
    input  logic               WVALID,
    output logic               WREADY,
    input  logic [DW-1:0]      WDATA,
    input  logic [DW/8-1:0]    WSTRB,
    input  logic               WLAST,
    output logic               BVALID,
    input  logic               BREADY,
    output logic [1:0]         BRESP,
    output logic [ID_SIZE-1:0] BID,
    input  logic               ARVALID,
    output logic               ARREADY,
    input  logic [AW-1:0]      ARADDR,
    input  logic [ID_SIZE-1:0] ARID,
    input  logic [3:0]         ARLEN,
    input  logic [2:0]         ARSIZE,
    input  logic [1:0]         ARBURST,
    output logic               RVALID,
    input  logic               RREADY,
    output logic [DW-1:0]      RDATA,
    output logic [1:0]         RRESP,
    output logic               RLAST,
    output logic [ID_SIZE-1:0] RID
);
    localparam int NB     = DW / 8;
    localparam int LG_BPW = $clog2(NB);
    localparam int LG_D   = $clog2(DEPTH);
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH * NB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [3:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] step, mask, inc;
        step = AW'(1) << size;
        mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        inc  = a + step;
        case (burst)
            2'd0:    return a;
            2'd2:    return (a & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    function automatic logic burst_err(input logic [3:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (burst == 2'd3) || (size > 3'(LG_BPW)) ||
               (burst == 2'd2 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    // A wrap block never straddles LIMIT, so only INCR needs its last beat checked.
    function automatic logic range_err(input logic [AW-1:0] a, input logic [3:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [AW:0] last;
        last = {1'b0, a} + ((AW+1)'(len) << size);
        return ({1'b0, a} >= LIMIT) || (burst == 2'd1 && last >= LIMIT);
    endfunction

    logic [DW-1:0] mem_q [DEPTH];

    // ---------------- write channel ----------------
    wstate_e w_state_q, w_state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [ID_SIZE-1:0] wid_q, wid_d, bid_q, bid_d;
    logic [3:0] wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [2:0] wsize_q, wsize_d;
    logic [1:0] wburst_q, wburst_d, bresp_q, bresp_d;
    logic wberr_q, wberr_d, werr_q, werr_d;
    logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic mem_we;
    logic [LG_D-1:0] mem_widx;

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wid_d     = wid_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wbeat_d   = wbeat_q;
        wberr_d   = wberr_q;
        werr_d    = werr_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        mem_we    = 1'b0;
        mem_widx  = waddr_q[LG_BPW +: LG_D];
        case (w_state_q)
            W_IDLE: if (AWVALID && awready_q) begin
                waddr_d   = AWADDR;
                wid_d     = AWID;
                wlen_d    = AWLEN;
                wsize_d   = AWSIZE;
                wburst_d  = AWBURST;
                wbeat_d   = 4'd0;
                wberr_d   = burst_err(AWLEN, AWSIZE, AWBURST);
                werr_d    = wberr_d || range_err(AWADDR, AWLEN, AWSIZE, AWBURST);
                w_state_d = W_DATA;
            end
            W_DATA: if (WVALID && wready_q) begin
                // Out-of-range beats are dropped individually; burst-level errors drop all.
                mem_we  = !wberr_q && ({1'b0, waddr_q} < LIMIT);
                if (WLAST != (wbeat_q == wlen_q)) werr_d = 1'b1;
                waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                wbeat_d = wbeat_q + 4'd1;
                if (wbeat_q == wlen_q) begin
                    w_state_d = W_RESP;
                    bresp_d   = werr_d ? 2'b10 : 2'b00;
                    bid_d     = wid_q;
                end
            end
            W_RESP: if (BREADY && bvalid_q) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wid_q     <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            wberr_q   <= 1'b0;
            werr_q    <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wid_q     <= wid_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            wberr_q   <= wberr_d;
            werr_q    <= werr_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // Memory is deliberately outside the reset domain so contents survive RSTN.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (WSTRB[b]) mem_q[mem_widx][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_e r_state_q, r_state_d;
    logic [AW-1:0] raddr_q, raddr_d, rnext;
    logic [3:0] rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [2:0] rsize_q, rsize_d;
    logic [1:0] rburst_q, rburst_d, rresp_q, rresp_d;
    logic rerr_q, rerr_d, arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [ID_SIZE-1:0] rid_q, rid_d;

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        rerr_d    = rerr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rnext     = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
        case (r_state_q)
            R_IDLE: if (ARVALID && arready_q) begin
                raddr_d   = ARADDR;
                rlen_d    = ARLEN;
                rsize_d   = ARSIZE;
                rburst_d  = ARBURST;
                rbeat_d   = 4'd0;
                rerr_d    = burst_err(ARLEN, ARSIZE, ARBURST) ||
                            range_err(ARADDR, ARLEN, ARSIZE, ARBURST);
                rdata_d   = rerr_d ? '0 : mem_q[ARADDR[LG_BPW +: LG_D]];
                rresp_d   = rerr_d ? 2'b10 : 2'b00;
                rlast_d   = (ARLEN == 4'd0);
                rid_d     = ARID;
                r_state_d = R_DATA;
            end
            R_DATA: if (RREADY && rvalid_q) begin
                if (rbeat_q == rlen_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    raddr_d = rnext;
                    rbeat_d = rbeat_q + 4'd1;
                    rdata_d = rerr_q ? '0 : mem_q[rnext[LG_BPW +: LG_D]];
                    rlast_d = (rbeat_q + 4'd1 == rlen_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
            rerr_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            rerr_q    <= rerr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign BID     = bid_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
endmodule
